// File: rtl/mc_fetch_seq.sv
// ---------------------------------------------------------------------------
// mc_fetch_seq
//
// Instruction sequencer sitting upstream of an MC14500B ICU. It owns the
// program counter, reads program words from a synchronous ROM and hands
// each 4-bit opcode to the ICU over a four-phase req/ack handshake. The
// ICU's jmp/rtn flags redirect the PC, and a small return-address stack
// provides subroutine call/return.
//
// Program word layout: {opcode[3:0], addr[ADDR_W-1:0]}.
//
// Handshake (four-phase, ICU side is asynchronous):
//   req_next rises with a stable opcode on instruction; the opcode is held
//   until req_next falls. The ICU raises ack_next to accept; the sequencer
//   then drops req_next and waits for ack_next to fall before the next
//   word. ack_next is double-flop synchronised, and a new acceptance needs
//   ack_next to be seen low inside REQ first, so a stale high ack can
//   never complete a handshake.
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   run          level; keep fetching while high
//   rom_addr     program ROM address (the fetch PC)
//   rom_data     ROM word, valid one clock after rom_addr
//   instruction  opcode to the ICU, stable while req_next is high
//   req_next     request to the ICU
//   ack_next     acknowledge from the ICU (asynchronous)
//   jmp, rtn     ICU redirect flags, sampled in NEXT only
//   pc           address of the most recently issued instruction
//   stk_err      sticky stack overflow/underflow flag
//   state_dbg    current FSM state
//   sp_dbg       return-stack depth
//   top_dbg      return-stack top entry (0 when empty)
// ---------------------------------------------------------------------------
module mc_fetch_seq #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W+3:0] rom_data,
    output logic [3:0]        instruction,
    output logic              req_next,
    input  logic              ack_next,
    input  logic              jmp,
    input  logic              rtn,
    output logic [ADDR_W-1:0] pc,
    output logic              stk_err,
    output logic [2:0]        state_dbg,
    output logic [SP_W-1:0]   sp_dbg,
    output logic [ADDR_W-1:0] top_dbg
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_REQ   = 3'd3,
        S_REL   = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic              ack_s1, ack_s2;
    logic              ack_armed;
    logic [ADDR_W-1:0] fetch_pc;
    logic [3:0]        instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] a_cur, a_prev;
    logic [ADDR_W-1:0] stk [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_m1;
    logic              err_q;

    assign sp_m1 = sp_q - 1'b1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_REQ;
            S_REQ:   if (ack_s2 && ack_armed) state_d = S_REL;
            S_REL:   if (!ack_s2) state_d = S_NEXT;
            S_NEXT:  state_d = run ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (req_next decodes straight from state so reset drops it
    // without waiting for a clock edge)
    // -----------------------------------------------------------------------
    always_comb begin
        req_next    = (state_q == S_REQ);
        rom_addr    = fetch_pc;
        instruction = instr_q;
        pc          = pc_q;
        stk_err     = err_q;
        state_dbg   = state_q;
        sp_dbg      = sp_q;
        top_dbg     = '0;
        if (sp_q != '0) begin
            top_dbg = stk[sp_m1[IDX_W-1:0]];
        end
    end

    // -----------------------------------------------------------------------
    // ack synchroniser. ack_armed records that ack was seen low during the
    // current REQ, so only a fresh rising edge is taken as acceptance.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1    <= 1'b0;
            ack_s2    <= 1'b0;
            ack_armed <= 1'b0;
        end else begin
            ack_s1 <= ack_next;
            ack_s2 <= ack_s1;
            if (state_q == S_LOAD) begin
                ack_armed <= 1'b0;
            end else if (state_q == S_REQ && !ack_s2) begin
                ack_armed <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: instruction latch, address history, PC and return stack.
    // a_prev holds the address field of the word before the one just
    // issued; with the one-slot delay that is the JMP word's target.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= '0;
            instr_q  <= '0;
            pc_q     <= '0;
            a_cur    <= '0;
            a_prev   <= '0;
            sp_q     <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    instr_q <= rom_data[ADDR_W+3:ADDR_W];
                    a_prev  <= a_cur;
                    a_cur   <= rom_data[ADDR_W-1:0];
                    pc_q    <= fetch_pc;
                end
                S_NEXT: begin
                    if (jmp) begin
                        // Return to the word after the delay slot; a full
                        // stack loses the return address but still jumps.
                        if (sp_q == SP_FULL) begin
                            err_q <= 1'b1;
                        end else begin
                            stk[sp_q[IDX_W-1:0]] <= pc_q + 1'b1;
                            sp_q                 <= sp_q + 1'b1;
                        end
                        fetch_pc <= a_prev;
                    end else if (rtn) begin
                        if (sp_q == '0) begin
                            err_q    <= 1'b1;
                            fetch_pc <= '0;
                        end else begin
                            fetch_pc <= stk[sp_m1[IDX_W-1:0]];
                            sp_q     <= sp_m1;
                        end
                    end else begin
                        fetch_pc <= fetch_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_fetch_seq.sv
module tb_mc_fetch_seq;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  instruction;
  logic        req_next;
  logic        ack_next;
  logic        jmp;
  logic        rtn;
  logic [7:0]  pc;
  logic        stk_err;
  logic [2:0]  state_dbg;
  logic [2:0]  sp_dbg;
  logic [7:0]  top_dbg;

  logic [11:0] rom [0:255];
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          got_rd;
  int          checks;
  int          errors;
  int          ack_dly;
  int          rel_dly;
  int          instr_changes;

  mc_fetch_seq #(.ADDR_W(8), .DEPTH(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instruction (instruction),
    .req_next    (req_next),
    .ack_next    (ack_next),
    .jmp         (jmp),
    .rtn         (rtn),
    .pc          (pc),
    .stk_err     (stk_err),
    .state_dbg   (state_dbg),
    .sp_dbg      (sp_dbg),
    .top_dbg     (top_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- synchronous ROM model ----------------
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- ICU model ----------------
  // Accepts each request after ack_dly clocks, releases ack rel_dly clocks
  // after req falls. Raises jmp/rtn while accepting the word that follows a
  // JMP (0xC) / RTN (0xD), holding the flag until the next acceptance.
  initial begin : icu
    logic [3:0] prev_op;
    int         wait_cnt;
    ack_next = 1'b0;
    jmp      = 1'b0;
    rtn      = 1'b0;
    prev_op  = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_op  = 4'h0;
        jmp      = 1'b0;
        rtn      = 1'b0;
        ack_next = 1'b0;
      end else if (req_next) begin
        repeat (ack_dly) @(negedge clk);
        if (req_next && !rst) begin
          got_q.push_back({instruction, pc});
          jmp      = (prev_op == 4'hC);
          rtn      = (prev_op == 4'hD);
          prev_op  = instruction;
          ack_next = 1'b1;
          wait_cnt = 0;
          while (req_next && wait_cnt < 1000) begin
            @(negedge clk);
            wait_cnt++;
          end
          repeat (rel_dly) @(negedge clk);
          ack_next = 1'b0;
        end
      end
    end
  end

  // Counts any opcode change while req_next stays high.
  initial begin : stab_mon
    logic       req_q;
    logic [3:0] instr_q;
    instr_changes = 0;
    req_q   = 1'b0;
    instr_q = 4'h0;
    forever begin
      @(negedge clk);
      if (req_next && req_q && instruction !== instr_q) instr_changes++;
      req_q   = req_next;
      instr_q = instruction;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_issues(input string tag, input int n);
    int cyc;
    cyc = 0;
    run = 1'b1;
    while (got_q.size() < got_rd + n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    while ((state_dbg != 3'd0 || req_next) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc >= 3000), 32'd0);
  endtask

  task automatic check_issues(input string tag);
    logic [11:0] e;
    logic [11:0] g;
    int          k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        g = got_q[got_rd];
        got_rd++;
      end else begin
        g = 'x;
      end
      chk($sformatf("%s_issue%0d", tag, k), {20'd0, g}, {20'd0, e});
      k++;
    end
    chk({tag, "_extra"}, 32'(got_q.size() - got_rd), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    rst     = 1'b1;
    run     = 1'b0;
    ack_dly = 0;
    rel_dly = 0;
    checks  = 0;
    errors  = 0;
    got_rd  = 0;
    clear_rom();
    do_reset();

    // reset values
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_req", 32'(req_next), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_err", 32'(stk_err), 32'h0);
    chk("rst_sp", 32'(sp_dbg), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);

    // linear run: LD, AND, STO, NOPO
    clear_rom();
    rom[0] = 12'h100; rom[1] = 12'h300; rom[2] = 12'h800; rom[3] = 12'h000;
    exp_q.push_back(12'h100); exp_q.push_back(12'h301);
    exp_q.push_back(12'h802); exp_q.push_back(12'h003);
    run_issues("lin", 4);
    check_issues("lin");
    chk("lin_pc", 32'(pc), 32'h3);
    chk("lin_rom_addr", 32'(rom_addr), 32'h4);
    chk("lin_err", 32'(stk_err), 32'h0);

    // jump with delay slot
    clear_rom();
    rom[0] = 12'h100; rom[1] = 12'h300; rom[2] = 12'hC40; rom[3] = 12'h800;
    rom[8'h40] = 12'h100;
    do_reset();
    exp_q.push_back(12'h100); exp_q.push_back(12'h301); exp_q.push_back(12'hC02);
    exp_q.push_back(12'h803); exp_q.push_back(12'h140);
    run_issues("jmp", 5);
    check_issues("jmp");
    chk("jmp_sp", 32'(sp_dbg), 32'h1);
    chk("jmp_top", 32'(top_dbg), 32'h4);
    chk("jmp_pc", 32'(pc), 32'h40);
    chk("jmp_err", 32'(stk_err), 32'h0);

    // call / return
    clear_rom();
    rom[0] = 12'h100; rom[1] = 12'h300; rom[2] = 12'hC40; rom[3] = 12'h800;
    rom[8'h40] = 12'h100; rom[8'h41] = 12'hD00; rom[8'h42] = 12'h300;
    rom[4] = 12'h800;
    do_reset();
    exp_q.push_back(12'h100); exp_q.push_back(12'h301); exp_q.push_back(12'hC02);
    exp_q.push_back(12'h803); exp_q.push_back(12'h140); exp_q.push_back(12'hD41);
    exp_q.push_back(12'h342); exp_q.push_back(12'h804);
    run_issues("call", 8);
    check_issues("call");
    chk("call_sp", 32'(sp_dbg), 32'h0);
    chk("call_pc", 32'(pc), 32'h4);
    chk("call_rom_addr", 32'(rom_addr), 32'h5);
    chk("call_err", 32'(stk_err), 32'h0);

    // reset while in REQ (ICU slow so the request is still open)
    ack_dly = 20;
    run = 1'b1;
    cyc = 0;
    while (!req_next && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rq_req_timeout", 32'(cyc >= 100), 32'd0);
    chk("rq_pc_pre", 32'(pc), 32'h5);
    @(negedge clk);
    #2 rst = 1'b1;
    run = 1'b0;
    #1;
    chk("rq_req_drop", 32'(req_next), 32'h0);
    chk("rq_state", 32'(state_dbg), 32'h0);
    chk("rq_pc", 32'(pc), 32'h0);
    chk("rq_rom_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rq_idle_hold", 32'(state_dbg), 32'h0);
    chk("rq_no_issue", 32'(got_q.size() - got_rd), 32'd0);
    ack_dly = 0;
    repeat (30) @(negedge clk);

    // stack overflow: five nested jumps
    clear_rom();
    rom[8'h00] = 12'hC10; rom[8'h01] = 12'h100;
    rom[8'h10] = 12'hC20; rom[8'h11] = 12'h100;
    rom[8'h20] = 12'hC30; rom[8'h21] = 12'h100;
    rom[8'h30] = 12'hC40; rom[8'h31] = 12'h100;
    rom[8'h40] = 12'hC50; rom[8'h41] = 12'h100;
    rom[8'h50] = 12'h300;
    do_reset();
    exp_q.push_back(12'hC00); exp_q.push_back(12'h101);
    exp_q.push_back(12'hC10); exp_q.push_back(12'h111);
    exp_q.push_back(12'hC20); exp_q.push_back(12'h121);
    exp_q.push_back(12'hC30); exp_q.push_back(12'h131);
    exp_q.push_back(12'hC40); exp_q.push_back(12'h141);
    exp_q.push_back(12'h350);
    run_issues("ovf", 11);
    check_issues("ovf");
    chk("ovf_sp", 32'(sp_dbg), 32'h4);
    chk("ovf_err", 32'(stk_err), 32'h1);
    chk("ovf_top", 32'(top_dbg), 32'h32);
    chk("ovf_pc", 32'(pc), 32'h50);

    // stack underflow after reset
    clear_rom();
    rom[0] = 12'hD00; rom[1] = 12'h100;
    do_reset();
    chk("unf_err_clr", 32'(stk_err), 32'h0);
    exp_q.push_back(12'hD00); exp_q.push_back(12'h101); exp_q.push_back(12'hD00);
    run_issues("unf", 3);
    check_issues("unf");
    chk("unf_err", 32'(stk_err), 32'h1);
    chk("unf_sp", 32'(sp_dbg), 32'h0);
    chk("unf_pc", 32'(pc), 32'h0);
    chk("unf_rom_addr", 32'(rom_addr), 32'h1);

    // PC wrap from all-ones
    clear_rom();
    rom[8'h00] = 12'hCFF; rom[8'h01] = 12'h100; rom[8'hFF] = 12'h300;
    do_reset();
    exp_q.push_back(12'hC00); exp_q.push_back(12'h101);
    exp_q.push_back(12'h3FF); exp_q.push_back(12'hC00);
    run_issues("wrap", 4);
    check_issues("wrap");
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_rom_addr", 32'(rom_addr), 32'h1);
    chk("wrap_sp", 32'(sp_dbg), 32'h1);
    chk("wrap_top", 32'(top_dbg), 32'h2);

    // slow ICU
    clear_rom();
    rom[0] = 12'h100; rom[1] = 12'h300; rom[2] = 12'h800;
    do_reset();
    ack_dly = 10;
    rel_dly = 7;
    exp_q.push_back(12'h100); exp_q.push_back(12'h301); exp_q.push_back(12'h802);
    run_issues("slow", 3);
    check_issues("slow");
    chk("slow_pc", 32'(pc), 32'h2);
    chk("slow_rom_addr", 32'(rom_addr), 32'h3);
    repeat (20) @(negedge clk);
    chk("instr_stable", 32'(instr_changes), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
